demux_1t2_8: RTL and testbench
==============================

// Module: demux_1t2_8
// PURPOSE
//  1-to-2 byte-stream demultiplexer: the distributing counterpart of the 2:1 byte mux.
//  Accepts one byte per cycle on a valid/ready input and routes it to output A (sel=0) or B (sel=1).
//  Each output has its own small FIFO, so a stalled sink never blocks traffic to the other sink.
//  Sits between the game-logic byte producer and two consumers (e.g. display path and sound/LED path).
// PARAMETERS
//  WIDTH  8   data width in bits
//  DEPTH  2   entries per output FIFO; power of 2, >=2
//  CNT_W  16  width of per-output delivered-byte counters
// PORTS
//  clk       in   1      system clock, rising edge
//  rst       in   1      asynchronous, active-high reset
//  in_data   in   WIDTH  input byte
//  in_sel    in   1      destination: 0 -> A, 1 -> B; sampled with in_data
//  in_valid  in   1      input byte present
//  in_ready  out  1      block accepts the byte this cycle
//  a_data    out  WIDTH  head of FIFO A
//  a_valid   out  1      FIFO A non-empty
//  a_ready   in   1      sink A takes a_data this cycle
//  b_data    out  WIDTH  head of FIFO B
//  b_valid   out  1      FIFO B non-empty
//  b_ready   in   1      sink B takes b_data this cycle
//  a_count   out  CNT_W  bytes delivered on A (a_valid&&a_ready), wraps mod 2^CNT_W
//  b_count   out  CNT_W  bytes delivered on B, wraps mod 2^CNT_W
// BEHAVIOUR
//  - Reset (async, any cycle): pointers, occupancy, storage, counters -> 0; a_valid=b_valid=0,
//    a_data=b_data=0, a_count=b_count=0; in_ready reflects empty FIFOs (=1 whenever rst=0 after reset).
//  - in_ready = in_sel ? !full_B : !full_A (combinational on in_sel and registered occupancy only;
//    never depends on a_ready/b_ready -> no same-cycle pass-through when full).
//  - Accept = in_valid && in_ready; byte written to selected FIFO at that rising edge.
//    in_valid=0 -> nothing written regardless of in_sel.
//  - Latency: accepted byte is visible on x_data with x_valid=1 the next cycle (if FIFO was empty).
//  - x_data = storage[rd_ptr] (registered storage, combinational read); x_valid = (occupancy != 0).
//    x_data holds stable while x_valid && !x_ready.
//  - Pop = x_valid && x_ready; advances rd_ptr, increments x_count same edge.
//  - Simultaneous push+pop on same FIFO: occupancy unchanged, both pointers advance; legal when
//    non-empty and not full. Full FIFO: push refused even if pop occurs that cycle.
//  - Empty FIFO with push: x_valid rises next cycle; x_ready while x_valid=0 is ignored.
//  - Pointers wrap mod DEPTH; occupancy counts 0..DEPTH (width clog2(DEPTH)+1).
//  - Order preserved per output; no ordering guarantee between A and B. No byte ever dropped or duplicated.
//  - Counters wrap from 2^CNT_W-1 to 0 silently.
// TESTING
//  1 Reset then 8 bytes 0x01..0x08, in_sel alternating 0,1, a_ready=b_ready=1 -> A sees 01,03,05,07,
//    B sees 02,04,06,08, each 1 cycle after accept; a_count=b_count=4; in_ready never drops.
//  2 a_ready=0, send 0x11,0x22 sel=0 -> A full, in_ready=0 for sel=0; then 0x33 sel=1 accepted,
//    b_valid=1 with 0x33 next cycle; a_data stays 0x11.
//  3 A full, a_ready=1 and 0x44 sel=0 offered same cycle -> 0x44 refused that cycle, accepted next;
//    A delivers 0x11,0x22,0x44 in order.
//  4 DEPTH=2, sink B toggling ready every cycle, 20 random bytes sel=1 -> scoreboard matches in order,
//    b_count=20, no loss or duplicate.
//  5 CNT_W=4, 17 bytes delivered on A -> a_count=1 (wrap).
//  6 Assert rst mid-stream with both FIFOs holding data, asynchronously between edges -> a_valid,
//    b_valid, counts, data go 0 immediately; after release first byte 0x5A sel=0 appears on A next cycle.

Source files
------------

// File: rtl/demux_1t2_8.sv
// demux_1t2_8: 1-to-2 byte-stream demultiplexer with an independent FIFO per output
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   in_data/in_sel         input byte and its destination (0 -> A, 1 -> B)
//   in_valid/in_ready      input handshake; ready only looks at the selected FIFO's fill
//   a_data/a_valid/a_ready head of FIFO A and its sink handshake
//   b_data/b_valid/b_ready head of FIFO B and its sink handshake
//   a_count/b_count        bytes delivered per output, wrapping
module demux_1t2_8_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    input  logic             ready,
    output logic [CNT_W-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop;
    assign valid   = occ_q != '0;
    assign full    = occ_q == OW'(DEPTH);
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = cnt_q;
    // x_ready while empty is ignored because pop is qualified by valid
    assign pop     = valid && ready;
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = wr_data;
        // DEPTH is a power of two, so pointer overflow is the wrap
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        occ_d    = occ_q + OW'(push) - OW'(pop);
        cnt_d    = cnt_q + CNT_W'(pop);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

module demux_1t2_8 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);
    logic full_a, full_b, push_a, push_b;
    // Ready depends only on registered fill, so a full FIFO refuses even when it pops this cycle
    assign in_ready = in_sel ? !full_b : !full_a;
    assign push_a   = in_valid && !in_sel && !full_a;
    assign push_b   = in_valid && in_sel && !full_b;
    demux_1t2_8_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo_a (
        .clk(clk), .rst(rst), .push(push_a), .wr_data(in_data), .full(full_a),
        .rd_data(a_data), .valid(a_valid), .ready(a_ready), .count(a_count)
    );
    demux_1t2_8_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo_b (
        .clk(clk), .rst(rst), .push(push_b), .wr_data(in_data), .full(full_b),
        .rd_data(b_data), .valid(b_valid), .ready(b_ready), .count(b_count)
    );
endmodule

// File: tb/tb_demux_1t2_8.sv
// tb_demux_1t2_8: directed self-checking bench for demux_1t2_8
module tb_demux_1t2_8;
    logic        clk = 0, rst = 1;
    logic [7:0]  in_data = 0;
    logic        in_sel = 0, in_valid = 0, a_ready = 0, b_ready = 0;
    logic        in_ready, a_valid, b_valid, in_ready4, a_valid4, b_valid4;
    logic [7:0]  a_data, b_data, a_data4, b_data4;
    logic [15:0] a_count, b_count;
    logic [3:0]  a_count4, b_count4;
    int total = 0, bad = 0;

    demux_1t2_8 u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(in_ready), .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready), .a_count(a_count), .b_count(b_count)
    );
    demux_1t2_8 #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(in_ready4), .a_data(a_data4), .a_valid(a_valid4), .a_ready(a_ready),
        .b_data(b_data4), .b_valid(b_valid4), .b_ready(b_ready), .a_count(a_count4), .b_count(b_count4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0; in_sel = 0; in_data = 0; a_ready = 0; b_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    logic [7:0] q[$];
    logic [7:0] vec[20];
    int occ, idx, cyc;
    logic push, pop;

    initial begin
        // test 1: alternating destinations, both sinks ready
        do_reset();
        chk("rst_a_valid", a_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_b_data", b_data, 0);
        chk("rst_a_count", a_count, 0);
        chk("rst_b_count", b_count, 0);
        chk("rst_in_ready", in_ready, 1);
        a_ready = 1; b_ready = 1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'(i + 1); in_sel = i[0]; in_valid = 1;
            #1 chk("t1_in_ready", in_ready, 1);
            step();
            chk("t1_a_valid", a_valid, !i[0]);
            chk("t1_b_valid", b_valid, i[0]);
            if (i[0]) chk("t1_b_data", b_data, 8'(i + 1));
            else      chk("t1_a_data", a_data, 8'(i + 1));
        end
        in_valid = 0;
        step();
        chk("t1_a_count", a_count, 4);
        chk("t1_b_count", b_count, 4);
        chk("t1_drained", {a_valid, b_valid}, 0);

        // test 2: fill A, B still accepts
        a_ready = 0; b_ready = 0;
        in_sel = 0; in_valid = 1; in_data = 8'h11;
        step();
        in_data = 8'h22;
        step();
        #1 chk("t2_full_a_ready", in_ready, 0);
        in_sel = 1; in_data = 8'h33;
        #1 chk("t2_b_ready", in_ready, 1);
        step();
        chk("t2_b_valid", b_valid, 1);
        chk("t2_b_data", b_data, 8'h33);
        chk("t2_a_hold", a_data, 8'h11);
        chk("t2_a_valid", a_valid, 1);

        // test 3: full A pops while 0x44 is offered; refused that cycle, taken next
        in_sel = 0; in_data = 8'h44; a_ready = 1;
        #1 chk("t3_refuse", in_ready, 0);
        step();
        chk("t3_a_data_22", a_data, 8'h22);
        chk("t3_ready_again", in_ready, 1);
        step();
        chk("t3_a_data_44", a_data, 8'h44);
        chk("t3_a_valid", a_valid, 1);
        in_valid = 0;
        step();
        chk("t3_a_empty", a_valid, 0);
        chk("t3_a_count", a_count, 7);
        b_ready = 1;
        step();
        chk("t3_b_empty", b_valid, 0);
        chk("t3_b_count", b_count, 5);

        // test 4: B sink toggles ready, scoreboard of 20 random bytes
        do_reset();
        foreach (vec[i]) vec[i] = 8'($urandom_range(0, 255));
        occ = 0; idx = 0; cyc = 0; q.delete();
        while ((idx < 20 || occ > 0) && cyc < 200) begin
            b_ready = cyc[0];
            in_sel = 1; in_valid = idx < 20; in_data = idx < 20 ? vec[idx] : 8'h00;
            #1;
            chk("t4_in_ready", in_ready, occ < 2);
            chk("t4_b_valid", b_valid, occ > 0);
            if (occ > 0) chk("t4_b_data", b_data, q[0]);
            push = in_valid && occ < 2;
            pop = occ > 0 && b_ready;
            if (pop) void'(q.pop_front());
            if (push) begin q.push_back(vec[idx]); idx++; end
            occ = occ + int'(push) - int'(pop);
            cyc++;
            step();
        end
        in_valid = 0;
        chk("t4_timeout", cyc < 200, 1);
        chk("t4_b_count", b_count, 20);
        chk("t4_a_count", a_count, 0);

        // test 5: 17 bytes on A wraps a 4-bit counter to 1
        do_reset();
        a_ready = 1; in_sel = 0; in_valid = 1;
        for (int i = 0; i < 17; i++) begin
            in_data = 8'(8'h80 + i);
            step();
        end
        in_valid = 0;
        step();
        chk("t5_a_count4", a_count4, 1);
        chk("t5_a_count16", a_count, 17);

        // test 6: async reset mid-cycle with both FIFOs holding data
        a_ready = 0; b_ready = 0;
        in_valid = 1; in_sel = 0; in_data = 8'hA1;
        step();
        in_sel = 1; in_data = 8'hB1;
        step();
        in_valid = 0;
        chk("t6_pre_a_valid", a_valid, 1);
        chk("t6_pre_b_valid", b_valid, 1);
        #2 rst = 1;
        #1;
        chk("t6_a_valid", a_valid, 0);
        chk("t6_b_valid", b_valid, 0);
        chk("t6_a_data", a_data, 0);
        chk("t6_b_data", b_data, 0);
        chk("t6_a_count", a_count, 0);
        chk("t6_b_count", b_count, 0);
        step();
        rst = 0;
        in_valid = 1; in_sel = 0; in_data = 8'h5A;
        step();
        in_valid = 0;
        chk("t6_post_a_valid", a_valid, 1);
        chk("t6_post_a_data", a_data, 8'h5A);
        chk("t6_post_b_valid", b_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
